// File: rtl/xor_frame_accumulator_if.sv
// -----------------------------------------------------------------------------
// xor_frame_accumulator_if
// Handshake bundle between a word-stream producer / result consumer (master)
// and the xor_frame_accumulator (slave).
//   in_valid / in_ready / in_data / in_last      : input word stream
//   out_valid / out_ready / out_xor / out_parity : frame result handshake
//   out_count                                    : saturating frame word count
//   exp_data / out_err                           : checksum compare, only when
//                                                  XOR_ACC_CHECK_EN is defined
// -----------------------------------------------------------------------------
interface xor_frame_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_xor;
  logic             out_parity;
  logic [CNT_W-1:0] out_count;
`ifdef XOR_ACC_CHECK_EN
  logic [WIDTH-1:0] exp_data;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_last, out_ready, exp_data,
    input  in_ready, out_valid, out_xor, out_parity, out_count, out_err
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready, exp_data,
    output in_ready, out_valid, out_xor, out_parity, out_count, out_err
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_xor, out_parity, out_count
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_xor, out_parity, out_count
  );
`endif
endinterface

// File: rtl/xor_frame_accumulator.sv
// -----------------------------------------------------------------------------
// xor_frame_accumulator
// Folds each frame of WIDTH-bit words (terminated by in_last) into one XOR
// checksum word, its parity bit and a saturating word count. The result is
// held until the consumer takes it; no input is accepted meanwhile.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : xor_frame_accumulator_if.slave (input stream + result handshake)
//
// Optional feature macro XOR_ACC_CHECK_EN: adds exp_data / out_err, comparing
// the frame checksum against exp_data sampled with the in_last word.
// -----------------------------------------------------------------------------
module xor_frame_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xor_frame_accumulator_if.slave bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Count increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == {CNT_W{1'b1}}) begin
      r = c;
    end else begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

  // Even/odd parity of a data word.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] xor_q,    xor_d;
  logic             par_q,    par_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             accept_s;
  logic [WIDTH-1:0] fold_s;
`ifdef XOR_ACC_CHECK_EN
  logic             err_q,    err_d;
`endif

  // Handshake flags depend on state only, so out_ready never reaches in_ready.
  assign bus.in_ready   = (state_q == ST_ACCUM);
  assign bus.out_valid  = (state_q == ST_HOLD);
  assign bus.out_xor    = xor_q;
  assign bus.out_parity = par_q;
  assign bus.out_count  = count_q;
`ifdef XOR_ACC_CHECK_EN
  assign bus.out_err    = err_q;
`endif

  assign accept_s = bus.in_valid && (state_q == ST_ACCUM);
  assign fold_s   = acc_q ^ bus.in_data;

  // Next-state logic: accumulate, close the frame, or release the result.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    par_d   = par_q;
    count_d = count_q;
`ifdef XOR_ACC_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (accept_s) begin
          if (bus.in_last) begin
            // Publish the frame and restart the accumulator from zero so the
            // next frame's first word loads directly.
            xor_d   = fold_s;
            par_d   = parity_f(fold_s);
            count_d = sat_inc(cnt_q);
`ifdef XOR_ACC_CHECK_EN
            err_d   = (fold_s != bus.exp_data);
`endif
            acc_d   = {WIDTH{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_HOLD;
          end else begin
            acc_d   = fold_s;
            cnt_d   = sat_inc(cnt_q);
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      xor_q   <= {WIDTH{1'b0}};
      par_q   <= 1'b0;
      count_q <= {CNT_W{1'b0}};
`ifdef XOR_ACC_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      par_q   <= par_d;
      count_q <= count_d;
`ifdef XOR_ACC_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_xor_frame_accumulator.sv
module tb_xor_frame_accumulator;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  xor_frame_accumulator_if #(.WIDTH(8), .CNT_W(8)) if_a ();
  xor_frame_accumulator_if #(.WIDTH(8), .CNT_W(2)) if_b ();

  xor_frame_accumulator #(.WIDTH(8), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  xor_frame_accumulator #(.WIDTH(8), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word on if_a until it is accepted; waited = stall cycles.
  task automatic push_a(input logic [7:0] d, input logic last, output int waited);
    logic rdy;
    if_a.in_valid = 1'b1;
    if_a.in_data  = d;
    if_a.in_last  = last;
    waited = 0;
    forever begin
      rdy = if_a.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        chk_cnt++;
        $display("FAIL push_timeout: word %h not accepted within %0d cycles", d, waited);
        break;
      end
    end
    if_a.in_valid = 1'b0;
    if_a.in_data  = 8'($urandom);
    if_a.in_last  = 1'($urandom);
  endtask

  task automatic push_b(input logic [7:0] d, input logic last);
    if_b.in_valid = 1'b1;
    if_b.in_data  = d;
    if_b.in_last  = last;
    @(posedge clk);
    #1;
    if_b.in_valid = 1'b0;
  endtask

  task automatic release_a();
    if_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_a.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    chk_cnt++; if (if_a.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", if_a.out_valid); else pass_cnt++;
    chk_cnt++; if (if_a.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", if_a.in_ready); else pass_cnt++;
    chk_cnt++; if (if_a.out_xor !== 8'h00 || if_a.out_count !== 8'h00 || if_a.out_parity !== 1'b0)
      $display("FAIL reset_results: got xor %h cnt %0d par %b want 0 0 0", if_a.out_xor, if_a.out_count, if_a.out_parity);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int w;
    push_a(8'hA5, 1'b1, w);
    chk_cnt++; if (if_a.out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", if_a.out_valid); else pass_cnt++;
    chk_cnt++; if (if_a.out_xor !== 8'hA5 || if_a.out_parity !== 1'b0 || if_a.out_count !== 8'd1)
      $display("FAIL single_result: got xor %h par %b cnt %0d want a5 0 1", if_a.out_xor, if_a.out_parity, if_a.out_count);
    else pass_cnt++;
    release_a();
    chk_cnt++; if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1)
      $display("FAIL single_release: got valid %b ready %b want 0 1", if_a.out_valid, if_a.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_four_word();
    int w;
    int stalls;
    logic [7:0] words [4];
    words = '{8'h01, 8'h02, 8'h04, 8'h80};
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      push_a(words[i], (i == 3), w);
      stalls += w;
    end
    chk_cnt++; if (stalls != 0) $display("FAIL four_throughput: got %0d stall cycles want 0", stalls); else pass_cnt++;
    chk_cnt++; if (if_a.out_xor !== 8'h87 || if_a.out_parity !== 1'b0 || if_a.out_count !== 8'd4)
      $display("FAIL four_result: got xor %h par %b cnt %0d want 87 0 4", if_a.out_xor, if_a.out_parity, if_a.out_count);
    else pass_cnt++;
    release_a();
    push_a(8'hFF, 1'b0, w);
    push_a(8'hFF, 1'b1, w);
    chk_cnt++; if (if_a.out_xor !== 8'h00 || if_a.out_parity !== 1'b0 || if_a.out_count !== 8'd2)
      $display("FAIL second_frame: got xor %h par %b cnt %0d want 00 0 2", if_a.out_xor, if_a.out_parity, if_a.out_count);
    else pass_cnt++;
    release_a();
  endtask

  task automatic test_backpressure();
    int w;
    push_a(8'hC3, 1'b1, w);
    if_a.in_valid = 1'b1;
    if_a.in_data  = 8'h5A;
    if_a.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_cnt++; if (if_a.in_ready !== 1'b0 || if_a.out_valid !== 1'b1 || if_a.out_xor !== 8'hC3 || if_a.out_count !== 8'd1)
        $display("FAIL bp_hold_%0d: got ready %b valid %b xor %h cnt %0d want 0 1 c3 1", i, if_a.in_ready, if_a.out_valid, if_a.out_xor, if_a.out_count);
      else pass_cnt++;
    end
    if_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_a.out_ready = 1'b0;
    chk_cnt++; if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1)
      $display("FAIL bp_release: got valid %b ready %b want 0 1", if_a.out_valid, if_a.in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    if_a.in_valid = 1'b0;
    chk_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_xor !== 8'h5A || if_a.out_count !== 8'd1)
      $display("FAIL bp_pending_word: got valid %b xor %h cnt %0d want 1 5a 1", if_a.out_valid, if_a.out_xor, if_a.out_count);
    else pass_cnt++;
    release_a();
  endtask

  task automatic test_reset_mid();
    int w;
    push_a(8'h0F, 1'b0, w);
    push_a(8'hF0, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (if_a.out_valid !== 1'b0 || if_a.in_ready !== 1'b1 || if_a.out_xor !== 8'h00 || if_a.out_count !== 8'd0 || if_a.out_parity !== 1'b0)
      $display("FAIL rst_mid_outputs: got valid %b ready %b xor %h cnt %0d par %b want 0 1 00 0 0",
               if_a.out_valid, if_a.in_ready, if_a.out_xor, if_a.out_count, if_a.out_parity);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    push_a(8'h3C, 1'b1, w);
    chk_cnt++; if (if_a.out_xor !== 8'h3C || if_a.out_count !== 8'd1 || if_a.out_valid !== 1'b1)
      $display("FAIL rst_mid_new_frame: got xor %h cnt %0d valid %b want 3c 1 1", if_a.out_xor, if_a.out_count, if_a.out_valid);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (if_a.out_valid !== 1'b0 || if_a.out_xor !== 8'h00 || if_a.in_ready !== 1'b1)
      $display("FAIL rst_hold: got valid %b xor %h ready %b want 0 00 1", if_a.out_valid, if_a.out_xor, if_a.in_ready);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 6; i++) push_b(8'h11, (i == 5));
    chk_cnt++; if (if_b.out_valid !== 1'b1 || if_b.out_count !== 2'd3 || if_b.out_xor !== 8'h00)
      $display("FAIL sat_six: got valid %b cnt %0d xor %h want 1 3 00", if_b.out_valid, if_b.out_count, if_b.out_xor);
    else pass_cnt++;
    if_b.out_ready = 1'b1; @(posedge clk); #1; if_b.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_b(8'h11 << i, (i == 2));
    chk_cnt++; if (if_b.out_count !== 2'd3 || if_b.out_xor !== 8'h77 || if_b.out_parity !== 1'b0)
      $display("FAIL sat_three: got cnt %0d xor %h par %b want 3 77 0", if_b.out_count, if_b.out_xor, if_b.out_parity);
    else pass_cnt++;
    if_b.out_ready = 1'b1; @(posedge clk); #1; if_b.out_ready = 1'b0;
    push_b(8'h01, 1'b0);
    push_b(8'h03, 1'b1);
    chk_cnt++; if (if_b.out_count !== 2'd2 || if_b.out_xor !== 8'h02 || if_b.out_parity !== 1'b1)
      $display("FAIL sat_two: got cnt %0d xor %h par %b want 2 02 1", if_b.out_count, if_b.out_xor, if_b.out_parity);
    else pass_cnt++;
    if_b.out_ready = 1'b1; @(posedge clk); #1; if_b.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int w;
    int n;
    int ones;
    logic [7:0] frame [$];
    logic [7:0] exp_xor;
    for (int f = 0; f < 25; f++) begin
      frame.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
      // Reference: XOR over the queue; parity from the total count of set bits.
      exp_xor = 8'h00;
      ones = 0;
      foreach (frame[i]) begin
        exp_xor = exp_xor ^ frame[i];
        ones += $countones(frame[i]);
      end
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if_a.in_valid = 1'b0;
          if_a.in_data  = 8'($urandom);
          if_a.in_last  = 1'b1;
          @(posedge clk);
          #1;
        end
        if_a.out_ready = 1'($urandom);
        push_a(frame[i], (i == n - 1), w);
        if_a.out_ready = 1'b0;
      end
      chk_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_xor !== exp_xor || if_a.out_count !== 8'(n) || if_a.out_parity !== 1'(ones % 2))
        $display("FAIL rand_frame_%0d: got valid %b xor %h cnt %0d par %b want 1 %h %0d %0d",
                 f, if_a.out_valid, if_a.out_xor, if_a.out_count, if_a.out_parity, exp_xor, n, ones % 2);
      else pass_cnt++;
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        @(posedge clk);
        #1;
      end
      chk_cnt++; if (if_a.out_valid !== 1'b1 || if_a.out_xor !== exp_xor)
        $display("FAIL rand_hold_%0d: got valid %b xor %h want 1 %h", f, if_a.out_valid, if_a.out_xor, exp_xor);
      else pass_cnt++;
      release_a();
    end
  endtask

`ifdef XOR_ACC_CHECK_EN
  task automatic test_check();
    int w;
    push_a(8'h12, 1'b0, w);
    if_a.exp_data = 8'h26;
    push_a(8'h34, 1'b1, w);
    if_a.exp_data = 8'hFF;
    chk_cnt++; if (if_a.out_err !== 1'b0 || if_a.out_xor !== 8'h26)
      $display("FAIL check_match: got err %b xor %h want 0 26", if_a.out_err, if_a.out_xor);
    else pass_cnt++;
    release_a();
    push_a(8'h12, 1'b0, w);
    if_a.exp_data = 8'h27;
    push_a(8'h34, 1'b1, w);
    if_a.exp_data = 8'h26;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_cnt++; if (if_a.out_err !== 1'b1)
        $display("FAIL check_mismatch_%0d: got err %b want 1", i, if_a.out_err);
      else pass_cnt++;
    end
    release_a();
  endtask
`endif

  initial begin
    chk_cnt        = 0;
    pass_cnt       = 0;
    rst_n          = 1'b0;
    if_a.in_valid  = 1'b0;
    if_a.in_data   = 8'h00;
    if_a.in_last   = 1'b0;
    if_a.out_ready = 1'b0;
    if_b.in_valid  = 1'b0;
    if_b.in_data   = 8'h00;
    if_b.in_last   = 1'b0;
    if_b.out_ready = 1'b0;
`ifdef XOR_ACC_CHECK_EN
    if_a.exp_data  = 8'h00;
    if_b.exp_data  = 8'h00;
`endif
    test_reset();
    test_single();
    test_four_word();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
`ifdef XOR_ACC_CHECK_EN
    test_check();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
